// File: rtl/table_loader.sv
// table_loader: writes a valid/ready stream of table words (or a whole-table zero-fill) into one RAM write port.
// Latency: 1 cycle from accepting edge to wr_*; s_ready low in CLEAR/SETTLE. Optional checksum: TABLE_LOADER_CHECKSUM_EN.
module table_loader #(
    parameter int DWIDTH     = 8,
    parameter int AWIDTH     = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    input  logic [DWIDTH-1:0] s_data,
    input  logic [AWIDTH-1:0] s_addr,
    input  logic              s_first,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              wr_en,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data,
    output logic              busy,
    output logic              table_valid,
    output logic              done,
    output logic              err,
    output logic [15:0]       load_csum
);
    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, SETTLE} state_t;

    localparam int                CW       = $clog2(RD_LATENCY + 2);
    localparam logic [AWIDTH-1:0] ADDR_MAX = '1;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DWIDTH-1:0] wr_data_q, wr_data_d;
    logic              table_valid_q, table_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;
    logic              at_max;
    logic              settle_end;

    assign s_ready    = (state_q == IDLE && !clear_req) || state_q == LOAD;
    assign accept     = s_valid && s_ready;
    assign at_max     = ptr_q == ADDR_MAX;
    assign settle_end = cnt_q == CW'(RD_LATENCY);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                end else if (accept && s_first) begin
                    state_d = s_last ? SETTLE : LOAD;
                end
            end
            CLEAR:   if (at_max) state_d = SETTLE;
            LOAD:    if (accept && s_last) state_d = SETTLE;
            SETTLE:  if (settle_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d         = ptr_q;
        cnt_d         = '0;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        table_valid_d = table_valid_q;
        done_d        = 1'b0;
        err_d         = err_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    ptr_d = '0;
                    err_d = 1'b0;
                end else if (accept) begin
                    if (s_first) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = s_addr;
                        wr_data_d = s_data;
                        ptr_d     = s_addr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = '0;
                ptr_d     = ptr_q + 1'b1;
            end
            LOAD: begin
                if (accept) begin
                    if (s_first) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = s_addr;
                        wr_data_d = s_data;
                        ptr_d     = s_addr;
                    end else if (at_max) begin
                        // Runs never wrap: the beat is consumed and dropped.
                        err_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q + 1'b1;
                        wr_data_d = s_data;
                        ptr_d     = ptr_q + 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (settle_end) begin
                    table_valid_d = 1'b1;
                    done_d        = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        // Readers must stop trusting the table from the first write onward.
        if (wr_en_d) table_valid_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q         <= '0;
            cnt_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            table_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            table_valid_q <= table_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = state_q != IDLE;
    assign table_valid = table_valid_q;
    assign done        = done_q;
    assign err         = err_q;

`ifdef TABLE_LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && (clear_req || (accept && s_first))) csum_d = '0;
        if (wr_en_d) csum_d = csum_d + 16'(wr_data_d);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign load_csum = csum_q;
`else
    assign load_csum = '0;
`endif

endmodule

// File: tb/tb_table_loader.sv
// Bench for table_loader: vector table for directed loads, hand-written clear/protocol/reset
// sequences, and randomized loads checked against an address-arithmetic table model.
module tb_table_loader;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int RDL   = 2;
    localparam int DEPTH = 256;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear_req = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [AW-1:0] s_addr = '0;
    logic          s_first = 1'b0;
    logic          s_last = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          table_valid;
    logic          done;
    logic          err;
    logic [15:0]   load_csum;

    table_loader #(.DWIDTH(DW), .AWIDTH(AW), .RD_LATENCY(RDL)) dut (
        .clock(clock), .reset(reset), .clear_req(clear_req),
        .s_data(s_data), .s_addr(s_addr), .s_first(s_first), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .table_valid(table_valid), .done(done), .err(err),
        .load_csum(load_csum)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Table contents as seen through the write port (captured mid-cycle).
    logic [DW-1:0] dut_mem [DEPTH];
    always @(negedge clock) if (wr_en === 1'b1) dut_mem[wr_addr] = wr_data;

    // Reference model state.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_ptr = 0;
    bit            m_active = 0;
    bit            m_err = 0;
    logic [15:0]   m_csum = '0;

    typedef struct {
        bit       first;
        bit [7:0] addr;
        bit [7:0] data;
        bit       last;
        bit       exp_wr;
        bit [7:0] exp_addr;
        bit [7:0] exp_data;
        bit       exp_err;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic model_beat(input bit first, input bit [7:0] addr, input bit [7:0] data,
                              input bit last, output bit w, output bit [7:0] wa);
        int target;
        w  = 0;
        wa = '0;
        if (!m_active) begin
            if (!first) begin
                m_err = 1;
                return;
            end
            m_csum   = '0;
            target   = int'(addr);
            m_active = !last;
        end else begin
            target = first ? int'(addr) : m_ptr + 1;
            if (last) m_active = 0;
        end
        if (target >= DEPTH) begin
            m_err = 1;
            return;
        end
        m_ptr       = target;
        w           = 1;
        wa          = target[7:0];
        m_mem[wa]   = data;
        m_csum      = m_csum + 16'(data);
    endtask

    task automatic drive_beat(input bit first, input bit [7:0] addr, input bit [7:0] data, input bit last);
        s_valid = 1'b1;
        s_first = first;
        s_addr  = addr;
        s_data  = data;
        s_last  = last;
        #1;
        chk("beat_ready", s_ready, 1);
        tick();
    endtask

    task automatic mem_compare(input string nm);
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (dut_mem[i] !== m_mem[i]) n++;
        chk({nm, "_mem"}, n, 0);
    endtask

    task automatic check_csum(input string nm);
`ifdef TABLE_LOADER_CHECKSUM_EN
        chk({nm, "_csum"}, load_csum, m_csum);
`else
        chk({nm, "_csum"}, load_csum, 0);
`endif
    endtask

    task automatic finish_load(input bit chk_lat, input string nm);
        int n = 0;
        s_valid = 1'b0;
        s_first = 1'b0;
        s_last  = 1'b0;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({nm, "_done"}, done, 1);
        if (chk_lat) chk({nm, "_lat"}, n, RDL + 1);
        chk({nm, "_tvalid"}, table_valid, 1);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_err"}, err, m_err);
        check_csum(nm);
        mem_compare(nm);
        tick();
        chk({nm, "_done_pulse"}, done, 0);
    endtask

    task automatic do_clear(input bit with_beat, input string nm);
        int n_wr = 0;
        int lat = -1;
        int seq_bad = 0;
        int tv_bad = 0;
        clear_req = 1'b1;
        s_valid   = with_beat;
        s_first   = 1'b1;
        s_addr    = 8'h5A;
        s_data    = 8'hEE;
        s_last    = 1'b1;
        #1;
        chk({nm, "_ready"}, s_ready, 0);
        tick();
        clear_req = 1'b0;
        s_valid   = 1'b0;
        s_first   = 1'b0;
        s_last    = 1'b0;
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_err"}, err, 0);
        m_err = 0; m_csum = '0; m_active = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        for (int i = 0; i < 400; i++) begin
            if (wr_en === 1'b1) begin
                if (wr_addr !== n_wr[7:0] || wr_data !== 8'h00) seq_bad++;
                if (table_valid !== 1'b0) tv_bad++;
                n_wr++;
                lat = 0;
            end else if (lat >= 0) begin
                lat++;
            end
            if (done === 1'b1) break;
            tick();
        end
        chk({nm, "_nwr"}, n_wr, DEPTH);
        chk({nm, "_seq"}, seq_bad, 0);
        chk({nm, "_tv_during"}, tv_bad, 0);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_lat"}, lat, RDL + 1);
        chk({nm, "_tvalid"}, table_valid, 1);
        chk({nm, "_err_end"}, err, 0);
        check_csum(nm);
        mem_compare(nm);
        tick();
        chk({nm, "_done_pulse"}, done, 0);
    endtask

    initial begin
        bit       w;
        bit [7:0] wa;

        //            first addr   data   last exp_wr exp_addr exp_data exp_err
        vecs[0]  = '{1, 8'h10, 8'hA1, 0, 1, 8'h10, 8'hA1, 0};
        vecs[1]  = '{0, 8'h00, 8'hA2, 0, 1, 8'h11, 8'hA2, 0};
        vecs[2]  = '{0, 8'h00, 8'hA3, 0, 1, 8'h12, 8'hA3, 0};
        vecs[3]  = '{0, 8'h00, 8'hA4, 1, 1, 8'h13, 8'hA4, 0};
        vecs[4]  = '{1, 8'h20, 8'h11, 0, 1, 8'h20, 8'h11, 0};
        vecs[5]  = '{0, 8'h00, 8'h22, 0, 1, 8'h21, 8'h22, 0};
        vecs[6]  = '{1, 8'h40, 8'h33, 0, 1, 8'h40, 8'h33, 0};
        vecs[7]  = '{0, 8'h00, 8'h44, 1, 1, 8'h41, 8'h44, 0};
        vecs[8]  = '{1, 8'hFE, 8'h01, 0, 1, 8'hFE, 8'h01, 0};
        vecs[9]  = '{0, 8'h00, 8'h02, 0, 1, 8'hFF, 8'h02, 0};
        vecs[10] = '{0, 8'h00, 8'h03, 0, 0, 8'h00, 8'h00, 1};
        vecs[11] = '{0, 8'h00, 8'h04, 1, 0, 8'h00, 8'h00, 1};

        repeat (3) tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tvalid", table_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_csum", load_csum, 0);
        reset = 1'b0;
        tick();
        chk("idle_ready", s_ready, 1);

        do_clear(0, "clr0");

        for (int r = 0; r < 12; r++) begin
            drive_beat(vecs[r].first, vecs[r].addr, vecs[r].data, vecs[r].last);
            model_beat(vecs[r].first, vecs[r].addr, vecs[r].data, vecs[r].last, w, wa);
            chk($sformatf("vec%0d_wr_en", r), wr_en, vecs[r].exp_wr);
            if (vecs[r].exp_wr) begin
                chk($sformatf("vec%0d_addr", r), wr_addr, vecs[r].exp_addr);
                chk($sformatf("vec%0d_data", r), wr_data, vecs[r].exp_data);
                chk($sformatf("vec%0d_tvalid", r), table_valid, 0);
            end
            chk($sformatf("vec%0d_err", r), err, vecs[r].exp_err);
            if (vecs[r].last) finish_load(vecs[r].exp_wr, $sformatf("vec%0d", r));
        end

        do_clear(0, "clr_after_ovf");

        drive_beat(0, 8'h33, 8'h77, 0);
        model_beat(0, 8'h33, 8'h77, 0, w, wa);
        s_valid = 1'b0;
        chk("proto_wr_en", wr_en, 0);
        chk("proto_err", err, 1);
        chk("proto_busy", busy, 0);
        tick();

        do_clear(1, "clr_collide");

        for (int l = 0; l < 30; l++) begin
            int       len;
            bit [7:0] base;
            len  = $urandom_range(1, 8);
            base = ($urandom_range(0, 2) == 0) ? 8'(8'hF8 + $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            for (int i = 0; i < len; i++) begin
                bit       f;
                bit       lst;
                bit [7:0] a;
                bit [7:0] d;
                if (i > 0 && $urandom_range(0, 3) == 0) begin
                    s_valid   = 1'b0;
                    clear_req = ($urandom_range(0, 1) == 1);
                    repeat ($urandom_range(1, 3)) begin
                        tick();
                        chk("stall_wr_en", wr_en, 0);
                        chk("stall_busy", busy, 1);
                    end
                    clear_req = 1'b0;
                end
                f   = (i == 0) || ($urandom_range(0, 9) == 0);
                a   = (i == 0) ? base : 8'($urandom_range(0, 255));
                d   = 8'($urandom_range(0, 255));
                lst = (i == len - 1);
                drive_beat(f, a, d, lst);
                model_beat(f, a, d, lst, w, wa);
                chk("rnd_wr_en", wr_en, w);
                if (w) begin
                    chk("rnd_addr", wr_addr, wa);
                    chk("rnd_data", wr_data, d);
                end
                chk("rnd_err", err, m_err);
            end
            finish_load(w, "rnd");
        end

        drive_beat(1, 8'h30, 8'h01, 0);
        model_beat(1, 8'h30, 8'h01, 0, w, wa);
        drive_beat(0, 8'h00, 8'h02, 0);
        model_beat(0, 8'h00, 8'h02, 0, w, wa);
        drive_beat(0, 8'h00, 8'h03, 0);
        chk("mid_wr_before", wr_en, 1);
        s_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("mid_wr_en", wr_en, 0);
        chk("mid_tvalid", table_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_err", err, 0);
        reset    = 1'b0;
        m_active = 0;
        m_err    = 0;
        tick();
        chk("mid_tvalid_idle", table_valid, 0);
        drive_beat(1, 8'h50, 8'hC1, 0);
        model_beat(1, 8'h50, 8'hC1, 0, w, wa);
        chk("post_wr0", wr_addr, 8'h50);
        drive_beat(0, 8'h00, 8'hC2, 0);
        model_beat(0, 8'h00, 8'hC2, 0, w, wa);
        chk("post_wr1", wr_addr, 8'h51);
        drive_beat(0, 8'h00, 8'hC3, 1);
        model_beat(0, 8'h00, 8'hC3, 1, w, wa);
        chk("post_wr2", wr_data, 8'hC3);
        finish_load(1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
